fetch_unit: RTL

Program-counter / instruction-register stage of the multicycle processor, sitting directly downstream of the control state machine and upstream of its Opcode input. It applies the control strobes (PCWrite, PCWriteBeq, PCWriteBne, PCData, IorD, IRegWrite, MemRead, MemWrite) to the PC, IR and memory data register. It also drives the unified memory address and tracks a ready/wait handshake with memory. While memory is busy it raises Stall, which freezes the control FSM.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC / IR / MDR stage of the multicycle core; applies control strobes and drives the unified memory address.
// Latency: zero-wait access captures at the edge ending the request cycle; PC loads are visible one cycle after the strobe.
// Backpressure: o_stall holds the control FSM while memory has not completed; a sticky bus error stops new accesses.
//
// Ports: i_clk/i_reset (sync, active-high); control strobes i_pc_write, i_pc_write_beq, i_pc_write_bne, i_pc_data,
//        i_iord, i_ireg_write, i_mem_read, i_mem_write; datapath i_alu_zero, i_alu_result, i_alu_out;
//        memory i_mem_data_in, i_mem_ready, o_mem_addr; state o_pc, o_instr, o_opcode, o_mdr; o_stall, o_bus_error.
// Optional: define FETCH_INSTR_CNT_EN to add o_instr_count, a wrapping count of instruction-register loads.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned MAX_WAIT = 8           // 1..255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pc_write,
   input  logic        i_pc_write_beq,
   input  logic        i_pc_write_bne,
   input  logic        i_pc_data,
   input  logic        i_iord,
   input  logic        i_ireg_write,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic        i_alu_zero,
   input  logic [15:0] i_alu_result,
   input  logic [15:0] i_alu_out,
   input  logic [15:0] i_mem_data_in,
   input  logic        i_mem_ready,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_pc,
   output logic [15:0] o_instr,
   output logic [3:0]  o_opcode,
   output logic [15:0] o_mdr,
   output logic        o_stall,
`ifdef FETCH_INSTR_CNT_EN
   output logic [15:0] o_instr_count,
`endif
   output logic        o_bus_error
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   // The request cycle in IDLE is itself the first wait cycle, so WAIT holds
   // MAX_WAIT-1 further wait cycles (counter values 0 .. MAX_WAIT-2). With
   // MAX_WAIT=1 the IDLE request cycle is already the last one allowed.
   localparam logic [7:0] LP_LAST = (MAX_WAIT > 1) ? 8'(MAX_WAIT - 2) : 8'd0;
   localparam logic       LP_ONE  = (MAX_WAIT == 1) ? 1'b1 : 1'b0;

   state_t      r_state;
   logic [7:0]  r_wait_cnt;
   logic [15:0] r_pc;
   logic [15:0] r_instr;
   logic [15:0] r_mdr;
   logic        r_bus_error;

   logic        w_req;
   logic        w_done;
   logic        w_timeout;
   logic        w_stall;
   logic        w_pc_en;
   logic [15:0] w_pc_next;
   logic        w_ir_load;

   // After a bus error requests are ignored entirely.
   assign w_req  = (i_mem_read | i_mem_write) & ~r_bus_error;
   assign w_done = w_req & i_mem_ready;

   // Final permitted wait cycle still without MemReady: raise the error at its edge.
   assign w_timeout = ~i_mem_ready &
                      ((r_state == ST_WAIT) ? (r_wait_cnt == LP_LAST) : (w_req & LP_ONE));

   assign w_stall = ~i_reset & ~i_mem_ready &
                    (((r_state == ST_IDLE) & w_req) | (r_state == ST_WAIT));

   assign w_pc_en   = (i_pc_write | (i_pc_write_beq & i_alu_zero) | (i_pc_write_bne & ~i_alu_zero))
                      & ~w_stall;
   // Halfword alignment: bit 0 of the PC is always zero.
   assign w_pc_next = (i_pc_data ? i_alu_out : i_alu_result) & 16'hFFFE;
   assign w_ir_load = w_done & i_mem_read & i_ireg_write;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= 8'd0;
         r_pc        <= RESET_PC;
         r_instr     <= 16'h0000;
         r_mdr       <= 16'h0000;
         r_bus_error <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req & ~i_mem_ready) begin
                  r_wait_cnt <= 8'd0;
                  if (w_timeout) r_bus_error <= 1'b1;
                  else           r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_mem_ready) begin
                  r_state <= ST_IDLE;
               end else if (w_timeout) begin
                  r_bus_error <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_done & i_mem_read) r_mdr   <= i_mem_data_in;
         if (w_ir_load)           r_instr <= i_mem_data_in;
         if (w_pc_en)             r_pc    <= w_pc_next;
      end
   end

`ifdef FETCH_INSTR_CNT_EN
   logic [15:0] r_instr_count;

   always_ff @(posedge i_clk) begin
      if (i_reset)        r_instr_count <= 16'h0000;
      else if (w_ir_load) r_instr_count <= r_instr_count + 16'h0001;   // wraps naturally
   end

   assign o_instr_count = r_instr_count;
`endif

   assign o_mem_addr  = i_iord ? i_alu_out : r_pc;
   assign o_pc        = r_pc;
   assign o_instr     = r_instr;
   assign o_opcode    = r_instr[15:12];
   assign o_mdr       = r_mdr;
   assign o_stall     = w_stall;
   assign o_bus_error = r_bus_error;

endmodule
